fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL provide parameter RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL provide parameter NOP_INSTR, 32'h0000_0013, instruction presented on InstrD when ValidD=0.
REQ-003 SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-007 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-008 SHALL have port imem_req_addr  output  32  fetch address (always equals PCF).
REQ-009 SHALL have port imem_rsp_valid  input  1  in-order instruction return.
REQ-010 SHALL have port imem_rsp_data  input  32  returned instruction word.
REQ-011 SHALL have port StallD  input  1  decode stage holding; do not pop.
REQ-012 SHALL have port PCSrcE  input  1  redirect request from execute.
REQ-013 SHALL have port PCTargetE  input  32  redirect target.
REQ-014 SHALL have port ValidD  output  1  InstrD/PCD/PCPlus4D hold a real instruction.
REQ-015 SHALL have ports InstrD, PCD, PCPlus4D  output  32 each  head-of-buffer instruction, its address, address+4.

Function
REQ-016 SHALL hold a fetch PC register PCF; on a request handshake (imem_req_valid & imem_req_ready) PCF SHALL advance by 4, wrapping modulo 2^32.
REQ-017 SHALL hold a 2-entry FIFO of {pc, instr} and an outstanding-request counter (0..2).
REQ-018 SHALL assert imem_req_valid only when occupancy + outstanding < 2, rst=0 and PCSrcE=0; no overflow is then possible.
REQ-019 SHALL keep imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-020 SHALL tag each accepted request with its address; the next non-discarded response SHALL be written with that tag; memory returns in order, latency >= 1 cycle.
REQ-021 SHALL drive ValidD = FIFO non-empty and PCSrcE=0; InstrD/PCD/PCPlus4D from the head; InstrD=NOP_INSTR, PCD=PCPlus4D=0 when ValidD=0.
REQ-022 SHALL pop the head at a clock edge when ValidD=1 and StallD=0; push and pop in the same cycle SHALL both occur, including when full.
REQ-023 On PCSrcE=1: PCF SHALL load {PCTargetE[31:2],2'b00}; FIFO SHALL empty; ValidD SHALL be 0 that cycle; a discard counter SHALL load the outstanding count after this cycle's response, if any, is consumed.
REQ-024 While the discard counter is non-zero, each response SHALL decrement it and SHALL NOT be written to the FIFO.
REQ-025 A second PCSrcE during discard SHALL reload the discard counter with the current outstanding count; the last redirect wins.
REQ-026 Hit-under-stall: with StallD=1 and FIFO full, no request SHALL issue and no data SHALL be lost.
REQ-027 First instruction SHALL be visible on ValidD one cycle after its response, i.e. latency request-accept to ValidD = memory latency + 1.
REQ-028 The block SHALL be a three-state control: RUN (normal), DRAIN (discard>0, requests allowed if credit permits), RESET; RESET->RUN on first edge after rst falls, RUN->DRAIN on PCSrcE with outstanding>0, DRAIN->RUN when discard reaches 0.

Reset
REQ-029 While rst=1: PCF=RESET_PC, FIFO empty, outstanding=0, discard=0, state=RESET, imem_req_valid=0, ValidD=0, InstrD=NOP_INSTR, PCD=PCPlus4D=0.
REQ-030 Reset asserted mid-transaction SHALL abandon all outstanding requests; the bench/memory SHALL also reset, and no stale response may be accepted after reset.

Verification
REQ-031 Reset release, 1-cycle memory always ready -> requests 0x0,0x4,0x8...; ValidD first high with PCD=0x0, PCPlus4D=0x4, one instruction per cycle thereafter.
REQ-032 imem_req_ready low 3 cycles at addr 0x8 -> imem_req_addr held 0x8, PCF not advanced, no duplicate fetch.
REQ-033 StallD=1 for 5 cycles with FIFO full -> imem_req_valid=0, InstrD unchanged; on release instructions resume in order, none dropped or repeated.
REQ-034 2 outstanding (3-cycle memory), PCSrcE=1 with PCTargetE=0x0000_0103 -> next request addr 0x100, both old responses discarded, first ValidD has PCD=0x100.
REQ-035 Back-to-back PCSrcE to 0x200 then 0x300 during DRAIN -> only 0x300 stream delivered, no 0x200 instruction ever valid.
REQ-036 PCF=0xFFFF_FFFC fetched -> next request addr 0x0000_0000, PCPlus4D=0x0000_0000 for that entry.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, credit-limited request issue,
// a 2-entry {pc, instr} buffer toward decode and discard of in-flight responses after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ValidD,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_pcf;
  logic [31:0] r_fifo_pc    [2];
  logic [31:0] r_fifo_instr [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;
  logic [31:0] r_tag [2];
  logic        r_tag_rd;
  logic        r_tag_wr;
  logic [1:0]  r_outst;
  logic [1:0]  r_discard;

  logic        w_valid_d;
  logic        w_pop;
  logic        w_rsp_take;
  logic        w_rsp_drop;
  logic        w_push;
  logic [2:0]  w_credit_sum;
  logic        w_req_valid;
  logic        w_hs;
  logic [1:0]  w_outst_next;
  logic [1:0]  w_discard_next;

  assign w_valid_d  = (r_count != 2'd0) && !PCSrcE;
  assign w_pop      = w_valid_d && !StallD;
  // A response with nothing outstanding can only be stale, so it is ignored.
  assign w_rsp_take = imem_rsp_valid && (r_outst != 2'd0);
  assign w_rsp_drop = w_rsp_take && ((r_discard != 2'd0) || PCSrcE);
  assign w_push     = w_rsp_take && !w_rsp_drop;

  // Occupancy is counted after this cycle's pop, so a steady 1-cycle memory
  // sustains one instruction per cycle while the buffer can never overflow.
  assign w_credit_sum = {1'b0, r_count} - {2'b00, w_pop} + {1'b0, r_outst};
  assign w_req_valid  = (r_state != S_RESET) && !rst && !PCSrcE && (w_credit_sum < 3'd2);
  assign w_hs         = w_req_valid && imem_req_ready;
  assign w_outst_next = r_outst + {1'b0, w_hs} - {1'b0, w_rsp_take};

  // Discard count: a redirect reloads it with what is still in flight.
  always_comb begin
    w_discard_next = r_discard;
    if (PCSrcE) begin
      w_discard_next = w_outst_next;
    end else if (w_rsp_take && (r_discard != 2'd0)) begin
      w_discard_next = r_discard - 2'd1;
    end else begin
      w_discard_next = r_discard;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Control next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RESET: w_state_next = S_RUN;
      S_RUN: begin
        if (PCSrcE && (w_discard_next != 2'd0)) begin
          w_state_next = S_DRAIN;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_discard_next == 2'd0) begin
          w_state_next = S_RUN;
        end else begin
          w_state_next = S_DRAIN;
        end
      end
      default: w_state_next = S_RESET;
    endcase
  end

  // PC, request tags, instruction buffer and counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcf           <= RESET_PC;
      r_fifo_pc[0]    <= 32'h0000_0000;
      r_fifo_pc[1]    <= 32'h0000_0000;
      r_fifo_instr[0] <= NOP_INSTR;
      r_fifo_instr[1] <= NOP_INSTR;
      r_rd_ptr        <= 1'b0;
      r_wr_ptr        <= 1'b0;
      r_count         <= 2'd0;
      r_tag[0]        <= 32'h0000_0000;
      r_tag[1]        <= 32'h0000_0000;
      r_tag_rd        <= 1'b0;
      r_tag_wr        <= 1'b0;
      r_outst         <= 2'd0;
      r_discard       <= 2'd0;
    end else begin
      r_outst   <= w_outst_next;
      r_discard <= w_discard_next;

      if (PCSrcE) begin
        r_pcf <= {PCTargetE[31:2], 2'b00};
      end else if (w_hs) begin
        r_pcf <= r_pcf + 32'd4;
      end

      // Tags stay queued across a redirect so discarded responses still retire theirs.
      if (w_hs) begin
        r_tag[r_tag_wr] <= r_pcf;
        r_tag_wr        <= ~r_tag_wr;
      end
      if (w_rsp_take) begin
        r_tag_rd <= ~r_tag_rd;
      end

      if (PCSrcE) begin
        r_count  <= 2'd0;
        r_rd_ptr <= 1'b0;
        r_wr_ptr <= 1'b0;
      end else begin
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]    <= r_tag[r_tag_rd];
          r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
          r_wr_ptr               <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  // Decode-side view of the buffer head.
  always_comb begin
    imem_req_valid = w_req_valid;
    imem_req_addr  = r_pcf;
    ValidD         = w_valid_d;
    if (w_valid_d) begin
      InstrD   = r_fifo_instr[r_rd_ptr];
      PCD      = r_fifo_pc[r_rd_ptr];
      PCPlus4D = r_fifo_pc[r_rd_ptr] + 32'd4;
    end else begin
      InstrD   = NOP_INSTR;
      PCD      = 32'h0000_0000;
      PCPlus4D = 32'h0000_0000;
    end
  end

endmodule
